// File: rtl/n64_vdemux_ng_pkg.sv
// Shared phase encodings, vdata_o field offsets and 16-bit-mode widths for the N64 video demux.
package n64_vdemux_ng_pkg;

   typedef enum logic [2:0] {
      PH_IDLE  = 3'd0,
      PH_SYNC  = 3'd1,
      PH_RED   = 3'd2,
      PH_GREEN = 3'd3,
      PH_BLUE  = 3'd4
   } phase_t;

   // Significant bits kept per channel when the console runs in 16-bit (5:6:5) colour.
   localparam int RB_KEEP_W = 5;
   localparam int G_KEEP_W  = 6;

   // vdata_o packs {sync, R, G, B}; blue sits at bit 0.
   function automatic int lsb_g(input int color_w);
      return color_w;
   endfunction

   function automatic int lsb_r(input int color_w);
      return 2 * color_w;
   endfunction

   function automatic int lsb_sync(input int color_w);
      return 3 * color_w;
   endfunction

   function automatic int drop_w(input int color_w, input int keep_w);
      return color_w - keep_w;
   endfunction

endpackage

// File: rtl/n64_vdemux_ng_phase.sv
// Pixel phase tracker for the multiplexed N64 video bus: per-phase capture strobes,
// pixel completion and saturating phase-error counting.
module n64_vdemux_phase
   import n64_vdemux_ng_pkg::*;
#(
   parameter int ERRCNT_W = 8
) (
   input  logic                VCLK,
   input  logic                nRST,
   input  logic                nDSYNC,
   output logic                cap_sync,
   output logic                cap_r,
   output logic                cap_g,
   output logic                cap_b,
   output logic                pix_done,
   output logic                phase_err_o,
   output logic [ERRCNT_W-1:0] err_cnt_o
);

   // state    | meaning
   // PH_IDLE  | lost alignment, waiting for nDSYNC low
   // PH_SYNC  | sync word captured
   // PH_RED   | red captured
   // PH_GREEN | green captured
   // PH_BLUE  | blue captured, pixel completes on the next sync phase

   phase_t state;
   logic   err_now;

   always_comb begin
      cap_sync = ~nDSYNC;
      cap_r    = nDSYNC & (state == PH_SYNC);
      cap_g    = nDSYNC & (state == PH_RED);
      cap_b    = nDSYNC & (state == PH_GREEN);
      pix_done = ~nDSYNC & (state == PH_BLUE);
      // Short pixel (sync during R/G) or overlong pixel (data after B).
      err_now  = (~nDSYNC & ((state == PH_RED) | (state == PH_GREEN)))
               | (nDSYNC & (state == PH_BLUE));
   end

   always_ff @(posedge VCLK or negedge nRST) begin
      if (!nRST) begin
         state       <= PH_IDLE;
         phase_err_o <= 1'b0;
         err_cnt_o   <= '0;
      end else begin
         phase_err_o <= err_now;
         if (err_now && (err_cnt_o != '1))
            err_cnt_o <= err_cnt_o + 1'b1;
         if (!nDSYNC) begin
            state <= PH_SYNC;
         end else begin
            case (state)
               PH_SYNC:  state <= PH_RED;
               PH_RED:   state <= PH_GREEN;
               PH_GREEN: state <= PH_BLUE;
               default:  state <= PH_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/n64_vdemux_ng.sv
// N64 multiplexed video demux: rebuilds {sync, R, G, B} pixels from the 4-phase bus.
// Optional deblur blanking is compiled in with `define VDEMUX_DEBLUR_EN.
module n64_vdemux_ng
   import n64_vdemux_ng_pkg::*;
#(
   parameter int COLOR_W  = 7,
   parameter int SYNC_W   = 4,
   parameter int ERRCNT_W = 8
) (
   input  logic                          VCLK,
   input  logic                          nRST,
   input  logic                          nDSYNC,
   input  logic [COLOR_W-1:0]            D_i,
   input  logic                          vmode_i,
   input  logic                          ndo_deblur_i,
   input  logic                          n16bit_mode_i,
   output logic [SYNC_W+3*COLOR_W-1:0]   vdata_o,
   output logic                          vdata_valid_o,
   output logic                          phase_err_o,
   output logic [ERRCNT_W-1:0]           err_cnt_o
);

   localparam int G_LSB = lsb_g(COLOR_W);
   localparam int R_LSB = lsb_r(COLOR_W);
   localparam int S_LSB = lsb_sync(COLOR_W);
   localparam logic [COLOR_W-1:0] ONES    = '1;
   localparam logic [COLOR_W-1:0] MASK_RB = ONES << drop_w(COLOR_W, RB_KEEP_W);
   localparam logic [COLOR_W-1:0] MASK_G  = ONES << drop_w(COLOR_W, G_KEEP_W);

   logic               cap_sync, cap_r, cap_g, cap_b, pix_done;
   logic [SYNC_W-1:0]  pend_sync;
   logic [COLOR_W-1:0] pend_r, pend_g, pend_b;
   logic [COLOR_W-1:0] r_out, g_out, b_out;
   logic               vsync_fall;
   logic               shadow_load;
   logic               sh_n16bit;
   logic               nblank;

   n64_vdemux_phase #(
      .ERRCNT_W (ERRCNT_W)
   ) u_phase (
      .VCLK        (VCLK),
      .nRST        (nRST),
      .nDSYNC      (nDSYNC),
      .cap_sync    (cap_sync),
      .cap_r       (cap_r),
      .cap_g       (cap_g),
      .cap_b       (cap_b),
      .pix_done    (pix_done),
      .phase_err_o (phase_err_o),
      .err_cnt_o   (err_cnt_o)
   );

   // Mode inputs are only trusted once per frame, on the red phase after nVSYNC falls.
   assign shadow_load = cap_r & vsync_fall;

   always_comb begin
      r_out = pend_r;
      g_out = pend_g;
      b_out = pend_b;
      if (!sh_n16bit) begin
         r_out = pend_r & MASK_RB;
         g_out = pend_g & MASK_G;
         b_out = pend_b & MASK_RB;
      end
   end

   always_ff @(posedge VCLK or negedge nRST) begin
      if (!nRST) begin
         pend_sync     <= '1;
         pend_r        <= '0;
         pend_g        <= '0;
         pend_b        <= '0;
         vsync_fall    <= 1'b0;
         sh_n16bit     <= 1'b1;
         vdata_o       <= {{SYNC_W{1'b1}}, {(3*COLOR_W){1'b0}}};
         vdata_valid_o <= 1'b0;
      end else begin
         vdata_valid_o <= pix_done;
         if (cap_sync) begin
            pend_sync <= D_i[SYNC_W-1:0];
            if (pend_sync[SYNC_W-1] && !D_i[SYNC_W-1])
               vsync_fall <= 1'b1;
         end
         if (cap_r) pend_r <= D_i;
         if (cap_g) pend_g <= D_i;
         if (cap_b) pend_b <= D_i;
         if (shadow_load) begin
            vsync_fall <= 1'b0;
            sh_n16bit  <= n16bit_mode_i;
         end
         if (pix_done) begin
            vdata_o[S_LSB +: SYNC_W] <= pend_sync;
            if (nblank) begin
               vdata_o[R_LSB +: COLOR_W] <= r_out;
               vdata_o[G_LSB +: COLOR_W] <= g_out;
               vdata_o[0     +: COLOR_W] <= b_out;
            end
         end
      end
   end

`ifdef VDEMUX_DEBLUR_EN
   logic sh_ndo_deblur;

   // A rising nCSYNC restarts the line, so its phase wins over the per-pixel toggle.
   always_ff @(posedge VCLK or negedge nRST) begin
      if (!nRST) begin
         sh_ndo_deblur <= 1'b1;
         nblank        <= 1'b1;
      end else begin
         if (shadow_load)
            sh_ndo_deblur <= ndo_deblur_i;
         if (cap_sync && !pend_sync[0] && D_i[0])
            nblank <= vmode_i;
         else if (pix_done && !sh_ndo_deblur)
            nblank <= ~nblank;
      end
   end
`else
   logic unused_deblur_cfg;

   assign nblank            = 1'b1;
   assign unused_deblur_cfg = ndo_deblur_i ^ vmode_i;
`endif

endmodule

// File: tb/tb_n64_vdemux_ng.sv
// Directed-vector bench for n64_vdemux_ng with a phase-counting reference model.
// Deblur expectations switch with VDEMUX_DEBLUR_EN to match the build.
`timescale 1ns/1ps
module tb_n64_vdemux_ng;

   localparam int CW = 7;
   localparam int SW = 4;
   localparam int EW = 8;
   localparam int VW = SW + 3*CW;

   logic          VCLK          = 1'b0;
   logic          nRST          = 1'b0;
   logic          nDSYNC        = 1'b1;
   logic [CW-1:0] D_i           = '0;
   logic          vmode_i       = 1'b0;
   logic          ndo_deblur_i  = 1'b1;
   logic          n16bit_mode_i = 1'b1;
   logic [VW-1:0] vdata_o;
   logic          vdata_valid_o;
   logic          phase_err_o;
   logic [EW-1:0] err_cnt_o;

   n64_vdemux_ng #(
      .COLOR_W  (CW),
      .SYNC_W   (SW),
      .ERRCNT_W (EW)
   ) dut (
      .VCLK          (VCLK),
      .nRST          (nRST),
      .nDSYNC        (nDSYNC),
      .D_i           (D_i),
      .vmode_i       (vmode_i),
      .ndo_deblur_i  (ndo_deblur_i),
      .n16bit_mode_i (n16bit_mode_i),
      .vdata_o       (vdata_o),
      .vdata_valid_o (vdata_valid_o),
      .phase_err_o   (phase_err_o),
      .err_cnt_o     (err_cnt_o)
   );

   always #5 VCLK = ~VCLK;

   int n_vec        = 0;
   int n_mis        = 0;
   int n_valid_seen = 0;

   // Model: m_cnt = high cycles since the last sync (-1 when alignment is lost).
   int            m_cnt;
   logic [SW-1:0] m_sync;
   logic [CW-1:0] m_px [3];
   bit            m_vfall, m_sh16, m_shdb, m_nblank;
   logic [VW-1:0] e_vdata;
   bit            e_valid, e_err;
   int            e_cnt;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [CW-1:0] pack16(input logic [CW-1:0] v, input int keep);
      int step;
      int x;
      if (m_sh16) return v;
      step = 1 << (CW - keep);
      x = (int'(v) / step) * step;
      return x[CW-1:0];
   endfunction

   task automatic m_reset();
      m_cnt    = -1;
      m_sync   = '1;
      m_vfall  = 1'b0;
      m_sh16   = 1'b1;
      m_shdb   = 1'b1;
      m_nblank = 1'b1;
      e_vdata  = {{SW{1'b1}}, {(3*CW){1'b0}}};
      e_valid  = 1'b0;
      e_err    = 1'b0;
      e_cnt    = 0;
   endtask

   task automatic m_step(input bit ns, input logic [CW-1:0] d);
      e_valid = 1'b0;
      e_err   = 1'b0;
      if (!ns) begin
         if (m_cnt == 1 || m_cnt == 2) e_err = 1'b1;
         if (m_cnt == 3) begin
            e_valid = 1'b1;
            e_vdata[VW-1 -: SW] = m_sync;
            if (m_nblank)
               e_vdata[3*CW-1:0] = {pack16(m_px[0], 5), pack16(m_px[1], 6), pack16(m_px[2], 5)};
`ifdef VDEMUX_DEBLUR_EN
            if (!m_shdb) m_nblank = !m_nblank;
`endif
         end
         if (m_sync[SW-1] && !d[SW-1]) m_vfall = 1'b1;
`ifdef VDEMUX_DEBLUR_EN
         if (!m_sync[0] && d[0]) m_nblank = vmode_i;
`endif
         m_sync = d[SW-1:0];
         m_cnt  = 0;
      end else if (m_cnt == 3) begin
         e_err = 1'b1;
         m_cnt = -1;
      end else if (m_cnt >= 0) begin
         if (m_cnt == 0 && m_vfall) begin
            m_vfall = 1'b0;
            m_sh16  = n16bit_mode_i;
            m_shdb  = ndo_deblur_i;
         end
         m_px[m_cnt] = d;
         m_cnt++;
      end
      if (e_err && e_cnt < (1 << EW) - 1) e_cnt++;
   endtask

   always @(posedge VCLK) begin
      #1;
      cmp("vdata", 32'(vdata_o), 32'(e_vdata));
      cmp("valid", 32'(vdata_valid_o), 32'(e_valid));
      cmp("phase_err", 32'(phase_err_o), 32'(e_err));
      cmp("err_cnt", 32'(err_cnt_o), 32'(e_cnt));
      if (vdata_valid_o) n_valid_seen++;
   end

   task automatic cyc(input bit ns, input logic [CW-1:0] d);
      nDSYNC = ns;
      D_i    = d;
      m_step(ns, d);
      @(negedge VCLK);
   endtask

   task automatic rgb(input logic [CW-1:0] r, input logic [CW-1:0] g, input logic [CW-1:0] b);
      cyc(1'b1, r);
      cyc(1'b1, g);
      cyc(1'b1, b);
   endtask

   initial begin
      m_reset();
      repeat (2) @(negedge VCLK);
      cmp("rst_sync", 32'(vdata_o[VW-1 -: SW]), 32'hF);
      cmp("rst_colour", 32'(vdata_o[3*CW-1:0]), 32'h0);
      cmp("rst_valid", 32'(vdata_valid_o), 32'h0);
      cmp("rst_errcnt", 32'(err_cnt_o), 32'h0);
      nRST = 1'b1;

      // Nominal pixel.
      cyc(1'b0, 7'h0F);
      rgb(7'h55, 7'h2A, 7'h7F);
      cyc(1'b0, 7'h0F);
      cmp("nom_vdata", 32'(vdata_o), 32'({4'hF, 7'h55, 7'h2A, 7'h7F}));
      cmp("nom_valid", 32'(vdata_valid_o), 32'h1);

      // 16-bit mode latched at an nVSYNC fall, held for the rest of the frame.
      n16bit_mode_i = 1'b0;
      cyc(1'b0, 7'h07);
      cyc(1'b1, 7'h7F);
      n16bit_mode_i = 1'b1;
      cyc(1'b1, 7'h7F);
      cyc(1'b1, 7'h7F);
      cyc(1'b0, 7'h0F);
      cmp("m16_vdata", 32'(vdata_o), 32'({4'h7, 7'h7C, 7'h7E, 7'h7C}));
      rgb(7'h41, 7'h43, 7'h45);
      cyc(1'b0, 7'h0F);
      cmp("m16_hold", 32'(vdata_o[3*CW-1:0]), 32'({7'h40, 7'h42, 7'h44}));
      cyc(1'b0, 7'h07);
      rgb(7'h12, 7'h34, 7'h56);
      cyc(1'b0, 7'h0F);
      cmp("m24_back", 32'(vdata_o[3*CW-1:0]), 32'({7'h12, 7'h34, 7'h56}));

      // Short pixel, then a clean one.
      cyc(1'b1, 7'h3C);
      cyc(1'b0, 7'h0F);
      cmp("short_err", 32'(phase_err_o), 32'h1);
      cmp("short_cnt", 32'(err_cnt_o), 32'h1);
      cmp("short_valid", 32'(vdata_valid_o), 32'h0);
      rgb(7'h11, 7'h22, 7'h33);
      cyc(1'b0, 7'h0F);
      cmp("after_short", 32'(vdata_o), 32'({4'hF, 7'h11, 7'h22, 7'h33}));

      // Overlong pixel drops to idle; stray data is ignored until the next sync.
      rgb(7'h01, 7'h02, 7'h03);
      cyc(1'b1, 7'h04);
      cmp("long_err", 32'(phase_err_o), 32'h1);
      cmp("long_valid", 32'(vdata_valid_o), 32'h0);
      cmp("long_cnt", 32'(err_cnt_o), 32'h2);
      cyc(1'b1, 7'h05);
      rgb(7'h66, 7'h67, 7'h68);
      cmp("idle_hold", 32'(vdata_o), 32'({4'hF, 7'h11, 7'h22, 7'h33}));

      // Error counter saturation.
      cyc(1'b0, 7'h0F);
      repeat (300) begin
         cyc(1'b1, 7'h10);
         cyc(1'b0, 7'h0F);
      end
      cmp("sat_cnt", 32'(err_cnt_o), 32'hFF);

      // Deblur: frame with ndo_deblur=0, line start via rising nCSYNC, four pixels.
      ndo_deblur_i = 1'b0;
      vmode_i      = 1'b1;
      cyc(1'b0, 7'h06);
      rgb(7'h01, 7'h02, 7'h03);
      cyc(1'b0, 7'h0F);
      rgb(7'h11, 7'h12, 7'h13);
      cyc(1'b0, 7'h0F);
      cmp("db_p1", 32'(vdata_o[3*CW-1:0]), 32'({7'h11, 7'h12, 7'h13}));
      rgb(7'h21, 7'h22, 7'h23);
      cyc(1'b0, 7'h0F);
      cmp("db_p2_valid", 32'(vdata_valid_o), 32'h1);
`ifdef VDEMUX_DEBLUR_EN
      cmp("db_p2", 32'(vdata_o[3*CW-1:0]), 32'({7'h11, 7'h12, 7'h13}));
`else
      cmp("db_p2", 32'(vdata_o[3*CW-1:0]), 32'({7'h21, 7'h22, 7'h23}));
`endif
      rgb(7'h31, 7'h32, 7'h33);
      cyc(1'b0, 7'h0F);
      cmp("db_p3", 32'(vdata_o[3*CW-1:0]), 32'({7'h31, 7'h32, 7'h33}));
      rgb(7'h41, 7'h42, 7'h43);
      cyc(1'b0, 7'h0F);
`ifdef VDEMUX_DEBLUR_EN
      cmp("db_p4", 32'(vdata_o[3*CW-1:0]), 32'({7'h31, 7'h32, 7'h33}));
`else
      cmp("db_p4", 32'(vdata_o[3*CW-1:0]), 32'({7'h41, 7'h42, 7'h43}));
`endif

      // Asynchronous reset mid-GREEN.
      cyc(1'b1, 7'h5A);
      cyc(1'b1, 7'h5B);
      nRST = 1'b0;
      #1;
      cmp("arst_sync", 32'(vdata_o[VW-1 -: SW]), 32'hF);
      cmp("arst_colour", 32'(vdata_o[3*CW-1:0]), 32'h0);
      cmp("arst_valid", 32'(vdata_valid_o), 32'h0);
      cmp("arst_err", 32'(phase_err_o), 32'h0);
      cmp("arst_cnt", 32'(err_cnt_o), 32'h0);
      m_reset();
      @(negedge VCLK);
      nRST = 1'b1;
      n_valid_seen = 0;
      rgb(7'h01, 7'h02, 7'h03);
      cyc(1'b0, 7'h0F);
      rgb(7'h6A, 7'h6B, 7'h6C);
      cyc(1'b0, 7'h0F);
      cyc(1'b1, 7'h00);
      cmp("arst_strobes", 32'(n_valid_seen), 32'h1);
      cmp("arst_pixel", 32'(vdata_o), 32'({4'hF, 7'h6A, 7'h6B, 7'h6C}));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
